deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_pkg.sv | 12 +
 rtl/deser_bit_counter.sv | 31 +++
 rtl/deserializer.sv | 91 +++++++++
 tb/tb_deserializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
// Imported by the top level and the bit counter.
package deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

endpackage : deserializer_pkg

// File: rtl/deser_bit_counter.sv
// Bit position counter: synchronous clear, advance on strobe,
// terminal-count flag at WIDTH-1 with wrap back to zero.
module deser_bit_counter
    import deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count;

    assign tc = (count == CW'(WIDTH - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule : deser_bit_counter

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel deserializer with gap-tolerant strobes,
// abort on Enable drop and back-to-back frame support.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ser_in,
    input  logic             bit_valid,
    input  logic             Enable,
    output logic [WIDTH-1:0] P_DATA,
    output logic             Data_Valid,
    output logic             Busy
);

    state_t state;
    state_t next_state;

    logic             clear;
    logic             capture;
    logic             done;
    logic             tc;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shifted;

    assign shifted = {ser_in, shift[WIDTH-1:1]};
    assign Busy    = (state == RECEIVE);

    deser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clear (clear),
        .inc   (capture),
        .tc    (tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A strobe arriving with Enable low is dropped in either state.
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Enable) begin
                    next_state = RECEIVE;
                    capture    = bit_valid;
                end else begin
                    clear = 1'b1;
                end
            end
            RECEIVE: begin
                if (Enable) begin
                    capture = bit_valid;
                end else begin
                    next_state = IDLE;
                    clear      = 1'b1;
                end
            end
        endcase
        done = capture && tc;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift      <= '0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
        end else begin
            Data_Valid <= done;
            if (capture) begin
                shift <= shifted;
            end
            if (done) begin
                P_DATA <= shifted;
            end
        end
    end

endmodule : deserializer

// File: tb/tb_deserializer.sv
// Scoreboard bench for the deserializer: stimulus queues expected words,
// an independent monitor checks every Data_Valid pulse against the queue.
module tb_deserializer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         ser_in;
    logic         bit_valid;
    logic         Enable;
    logic [W-1:0] P_DATA;
    logic         Data_Valid;
    logic         Busy;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;
    int cyc        = 0;

    logic [W-1:0] exp_q[$];

    deserializer #(
        .WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ser_in     (ser_in),
        .bit_valid  (bit_valid),
        .Enable     (Enable),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RST === 1'b0 && Data_Valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                chk("p_data", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        ser_in    = b;
        bit_valid = 1'b1;
        @(posedge CLK);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input bit gaps,
                              output int t_done);
        exp_q.push_back(word);
        for (int i = 0; i < W; i++) begin
            if (gaps) idle(i % 4);
            strobe(word[i]);
            chk("busy_in_frame", {31'd0, Busy}, 32'd1);
            if (i == W - 1) chk("dv_latency", {31'd0, Data_Valid}, 32'd1);
            else            chk("dv_early", {31'd0, Data_Valid}, 32'd0);
        end
        t_done = cyc;
    endtask

    initial begin
        int t1;
        int t2;
        int p0;
        logic [7:0] a5_bits;

        RST       = 1'b1;
        ser_in    = 1'b0;
        bit_valid = 1'b0;
        Enable    = 1'b0;
        idle(3);
        chk("rst_p_data", {24'd0, P_DATA}, 32'd0);
        chk("rst_dv", {31'd0, Data_Valid}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        RST = 1'b0;

        // Idle with Enable low ignores strobes
        strobe(1'b1);
        strobe(1'b1);
        chk("idle_busy", {31'd0, Busy}, 32'd0);

        // 0xA5 on consecutive strobes
        Enable = 1'b1;
        idle(1);
        chk("enter_receive", {31'd0, Busy}, 32'd1);
        a5_bits = 8'hA5;
        send_frame(a5_bits, 1'b0, t1);
        Enable = 1'b0;
        idle(2);
        chk("back_to_idle", {31'd0, Busy}, 32'd0);
        chk("hold_a5", {24'd0, P_DATA}, 32'hA5);

        // 0x3C with 0..3 idle cycles between strobes
        p0 = pulses;
        Enable = 1'b1;
        idle(1);
        send_frame(8'h3C, 1'b1, t1);
        idle(4);
        chk("3c_once", pulses, p0 + 1);
        chk("hold_3c", {24'd0, P_DATA}, 32'h3C);

        // Abort after three bits of 0xFF; strobe in abort cycle dropped
        p0 = pulses;
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b1);
        Enable = 1'b0;
        strobe(1'b1);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        idle(2);
        chk("abort_no_pulse", pulses, p0);
        chk("abort_hold", {24'd0, P_DATA}, 32'h3C);
        Enable = 1'b1;
        idle(1);
        send_frame(8'h5A, 1'b0, t1);
        idle(2);
        chk("after_abort", {24'd0, P_DATA}, 32'h5A);

        // Back-to-back 0x5A, 0xC3
        p0 = pulses;
        send_frame(8'h5A, 1'b0, t1);
        send_frame(8'hC3, 1'b0, t2);
        chk("b2b_spacing", t2 - t1, 32'd8);
        idle(2);
        chk("b2b_pulses", pulses, p0 + 2);
        chk("b2b_last", {24'd0, P_DATA}, 32'hC3);

        // Reset after five bits of 0x81
        p0 = pulses;
        strobe(1'b1);
        for (int i = 0; i < 4; i++) strobe(1'b0);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_p_data", {24'd0, P_DATA}, 32'd0);
        chk("mid_rst_dv", {31'd0, Data_Valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
        idle(2);
        RST = 1'b0;
        idle(1);
        send_frame(8'h81, 1'b0, t1);
        idle(3);
        chk("rst_single_pulse", pulses, p0 + 1);
        chk("rst_p_81", {24'd0, P_DATA}, 32'h81);

        // Enable and first strobe together from IDLE
        Enable = 1'b0;
        idle(2);
        chk("pre_01_idle", {31'd0, Busy}, 32'd0);
        exp_q.push_back(8'h01);
        Enable    = 1'b1;
        ser_in    = 1'b1;
        bit_valid = 1'b1;
        @(posedge CLK);
        #1;
        bit_valid = 1'b0;
        chk("joint_busy", {31'd0, Busy}, 32'd1);
        for (int i = 1; i < W; i++) strobe(1'b0);
        chk("joint_dv", {31'd0, Data_Valid}, 32'd1);
        idle(3);
        chk("joint_p_01", {24'd0, P_DATA}, 32'h01);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_deserializer
